dco_fsk_cal_ctrl: RTL and testbench

- Controller sitting in front of the 7-bit coarse-tuned DCO in the FSK modem.
- On request, binary-searches (SAR) the coarse code separately for the MARK and SPACE tone frequencies, using an external DCO edge counter through a start/done handshake.
- After calibration, it drives the DCO coarse code from TX_DATA: 1 selects the MARK code, 0 selects the SPACE code.

---
 rtl/dco_fsk_cal_ctrl.sv | 206 ++++++++++++++++++++
 tb/tb_dco_fsk_cal_ctrl.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dco_fsk_cal_ctrl.sv
// Coarse-code calibration controller for the FSK modem DCO: runs an MSB-first SAR per tone
// (MARK, then SPACE) against an external edge counter, then steers COARSE from TX_DATA.
module dco_fsk_cal_ctrl #(
  parameter int CODE_W  = 7,
  parameter int CW      = 12,
  parameter int SETTLE  = 8,
  parameter int TIMEOUT = 1023,
  parameter bit DIR     = 1'b0
) (
  input  logic              REF_CLK,
  input  logic              RESET_,
  input  logic              CAL_START,
  input  logic [CW-1:0]     TGT_MARK,
  input  logic [CW-1:0]     TGT_SPACE,
  input  logic              TX_DATA,
  output logic              CNT_START,
  input  logic              CNT_DONE,
  input  logic [CW-1:0]     CNT_VAL,
  output logic [CODE_W-1:0] COARSE,
  output logic [CODE_W-1:0] MARK_CODE,
  output logic [CODE_W-1:0] SPACE_CODE,
  output logic              CAL_BUSY,
  output logic              CAL_DONE,
  output logic              CAL_ERR,
  output logic [2:0]        STATE_DBG
);

  localparam int BW   = (CODE_W > 1) ? $clog2(CODE_W) : 1;
  localparam int CMAX = (SETTLE > TIMEOUT) ? SETTLE : TIMEOUT;
  localparam int CNTW = $clog2(CMAX + 1);

  localparam logic [CODE_W-1:0] MID_CODE    = CODE_W'(1) << (CODE_W - 1);
  localparam logic [BW-1:0]     TOP_BIT     = BW'(CODE_W - 1);
  localparam logic [CNTW-1:0]   SETTLE_LAST = CNTW'(SETTLE - 1);
  // The timeout counter starts at 0 in the first WAIT cycle, so firing at TIMEOUT-2 puts
  // CAL_ERR high exactly TIMEOUT cycles after the CNT_START cycle (TIMEOUT must be >= 2).
  localparam logic [CNTW-1:0]   TMO_LAST    = CNTW'(TIMEOUT - 2);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SET    = 3'd1,
    S_MEAS   = 3'd2,
    S_WAIT   = 3'd3,
    S_DECIDE = 3'd4,
    S_NEXT   = 3'd5
  } state_e;

  state_e              state_q, state_d;
  logic [CODE_W-1:0]   coarse_q, coarse_d;
  logic [CODE_W-1:0]   mark_q, mark_d;
  logic [CODE_W-1:0]   space_q, space_d;
  logic [CODE_W-1:0]   result_q, result_d;
  logic [BW-1:0]       bit_q, bit_d;
  logic                tone_q, tone_d;
  logic [CNTW-1:0]     cnt_q, cnt_d;
  logic [CW-1:0]       tgt_mark_q, tgt_mark_d;
  logic [CW-1:0]       tgt_space_q, tgt_space_d;
  logic [CW-1:0]       cap_q, cap_d;
  logic                cnt_start_q, cnt_start_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                err_q, err_d;

  logic [CW-1:0]       tgt_cur;
  logic                keep;
  logic                tmo_fire;

  assign tgt_cur  = tone_q ? tgt_space_q : tgt_mark_q;
  assign keep     = DIR ? (cap_q >= tgt_cur) : (cap_q <= tgt_cur);
  assign tmo_fire = (cnt_q == TMO_LAST);

  always_ff @(posedge REF_CLK or negedge RESET_) begin
    if (!RESET_) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (CAL_START) state_d = S_SET;
      S_SET:    if (cnt_q == SETTLE_LAST) state_d = S_MEAS;
      S_MEAS:   state_d = S_WAIT;
      S_WAIT: begin
        if (CNT_DONE)      state_d = S_DECIDE;
        else if (tmo_fire) state_d = S_IDLE;
      end
      S_DECIDE: state_d = (bit_q == '0) ? S_NEXT : S_SET;
      S_NEXT:   state_d = tone_q ? S_IDLE : S_SET;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    mark_d      = mark_q;
    space_d     = space_q;
    result_d    = result_q;
    bit_d       = bit_q;
    tone_d      = tone_q;
    cnt_d       = cnt_q;
    tgt_mark_d  = tgt_mark_q;
    tgt_space_d = tgt_space_q;
    cap_d       = cap_q;
    busy_d      = busy_q;
    done_d      = done_q;
    err_d       = err_q;
    case (state_q)
      S_IDLE: begin
        if (CAL_START) begin
          tgt_mark_d  = TGT_MARK;
          tgt_space_d = TGT_SPACE;
          done_d      = 1'b0;
          err_d       = 1'b0;
          busy_d      = 1'b1;
          result_d    = '0;
          bit_d       = TOP_BIT;
          tone_d      = 1'b0;
          cnt_d       = '0;
        end
      end
      S_SET:  cnt_d = cnt_q + CNTW'(1);
      S_MEAS: cnt_d = '0;
      S_WAIT: begin
        if (CNT_DONE) begin
          cap_d = CNT_VAL;
        end else if (tmo_fire) begin
          err_d  = 1'b1;
          busy_d = 1'b0;
          done_d = 1'b0;
        end else begin
          cnt_d = cnt_q + CNTW'(1);
        end
      end
      S_DECIDE: begin
        if (keep) result_d = result_q | (CODE_W'(1) << bit_q);
        if (bit_q != '0) begin
          bit_d = bit_q - BW'(1);
          cnt_d = '0;
        end
      end
      S_NEXT: begin
        if (!tone_q) begin
          mark_d   = result_q;
          result_d = '0;
          bit_d    = TOP_BIT;
          tone_d   = 1'b1;
          cnt_d    = '0;
        end else begin
          space_d = result_q;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end
      end
      default: ;
    endcase

    // COARSE is loaded from next-state values so each trial code is on the DCO for the whole SET window.
    if (state_d == S_SET)       coarse_d = result_d | (CODE_W'(1) << bit_d);
    else if (state_d == S_IDLE) coarse_d = done_d ? (TX_DATA ? mark_d : space_d) : MID_CODE;
    else                        coarse_d = coarse_q;
    cnt_start_d = (state_d == S_MEAS);
  end

  always_ff @(posedge REF_CLK or negedge RESET_) begin
    if (!RESET_) begin
      coarse_q    <= MID_CODE;
      mark_q      <= '0;
      space_q     <= '0;
      result_q    <= '0;
      bit_q       <= '0;
      tone_q      <= 1'b0;
      cnt_q       <= '0;
      tgt_mark_q  <= '0;
      tgt_space_q <= '0;
      cap_q       <= '0;
      cnt_start_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      coarse_q    <= coarse_d;
      mark_q      <= mark_d;
      space_q     <= space_d;
      result_q    <= result_d;
      bit_q       <= bit_d;
      tone_q      <= tone_d;
      cnt_q       <= cnt_d;
      tgt_mark_q  <= tgt_mark_d;
      tgt_space_q <= tgt_space_d;
      cap_q       <= cap_d;
      cnt_start_q <= cnt_start_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign COARSE     = coarse_q;
  assign MARK_CODE  = mark_q;
  assign SPACE_CODE = space_q;
  assign CNT_START  = cnt_start_q;
  assign CAL_BUSY   = busy_q;
  assign CAL_DONE   = done_q;
  assign CAL_ERR    = err_q;
  assign STATE_DBG  = state_q;

endmodule

// File: tb/tb_dco_fsk_cal_ctrl.sv
// Bench for dco_fsk_cal_ctrl: a linear DCO model answers the counter handshake; calibration
// results and trial codes are predicted from the tone targets and checked by monitor processes.
module tb_dco_fsk_cal_ctrl;
  localparam int CODE_W = 7;
  localparam int CW     = 12;
  localparam int LAT    = 5;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              cal_start;
  logic [CW-1:0]     tgt_mark, tgt_space;
  logic              tx_data;
  logic              cnt_start;
  logic              cnt_done;
  logic [CW-1:0]     cnt_val;
  logic [CODE_W-1:0] coarse, mark_code, space_code;
  logic              cal_busy, cal_done, cal_err;
  logic [2:0]        state_dbg;

  logic              resp_done = 1'b0;
  logic              stray_done = 1'b0;
  logic [CW-1:0]     resp_val = '0;

  assign cnt_done = resp_done | stray_done;
  assign cnt_val  = resp_val;

  dco_fsk_cal_ctrl dut (
    .REF_CLK(clk), .RESET_(rst_n), .CAL_START(cal_start),
    .TGT_MARK(tgt_mark), .TGT_SPACE(tgt_space), .TX_DATA(tx_data),
    .CNT_START(cnt_start), .CNT_DONE(cnt_done), .CNT_VAL(cnt_val),
    .COARSE(coarse), .MARK_CODE(mark_code), .SPACE_CODE(space_code),
    .CAL_BUSY(cal_busy), .CAL_DONE(cal_done), .CAL_ERR(cal_err),
    .STATE_DBG(state_dbg)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  logic [15:0]       exp_q[$];
  logic [CODE_W-1:0] trial_q[$];
  int start_cnt = 0;
  bit resp_en = 1'b1;
  int slope = 10;
  int offset = 100;
  logic [CODE_W-1:0] prev_mark = '0, prev_space = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int dco_count(input int code);
    return slope * code + offset;
  endfunction

  // The DCO model is monotone, so the right code is simply the largest one not above target.
  function automatic logic [CODE_W-1:0] best_code(input int tgt);
    int best = 0;
    for (int c = 0; c < (1 << CODE_W); c++)
      if (dco_count(c) <= tgt) best = c;
    return CODE_W'(best);
  endfunction

  task automatic push_trials(input int tgt);
    int res = 0;
    int t;
    for (int b = CODE_W - 1; b >= 0; b--) begin
      t = res | (1 << b);
      trial_q.push_back(CODE_W'(t));
      if (dco_count(t) <= tgt) res = t;
    end
  endtask

  // Edge-counter responder: answers each CNT_START LAT cycles later with the model count.
  initial begin
    int code;
    forever begin
      @(negedge clk);
      if (rst_n && cnt_start && resp_en) begin
        code = int'(coarse);
        repeat (LAT) @(negedge clk);
        resp_val  = CW'(dco_count(code));
        resp_done = 1'b1;
        @(negedge clk);
        resp_done = 1'b0;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && cnt_start) begin
        start_cnt++;
        if (trial_q.size() == 0) check("cnt_start_unexpected", {31'd0, cnt_start}, 32'd0);
        else                     check("trial_code", {25'd0, coarse}, {25'd0, trial_q.pop_front()});
      end
    end
  end

  initial begin
    logic prev_busy = 1'b0;
    logic [15:0] e;
    forever begin
      @(negedge clk);
      if (rst_n && prev_busy && !cal_busy) begin
        if (exp_q.size() == 0) begin
          check("cal_end_unexpected", {31'd0, cal_busy}, 32'd1);
        end else begin
          e = exp_q.pop_front();
          check("mark_code", {25'd0, mark_code}, {25'd0, e[6:0]});
          check("space_code", {25'd0, space_code}, {25'd0, e[13:7]});
          check("cal_done", {31'd0, cal_done}, {31'd0, e[14]});
          check("cal_err", {31'd0, cal_err}, {31'd0, e[15]});
        end
      end
      prev_busy = cal_busy;
    end
  end

  task automatic pulse_start(input int tm, input int ts);
    @(negedge clk);
    tgt_mark  = CW'(tm);
    tgt_space = CW'(ts);
    cal_start = 1'b1;
    @(negedge clk);
    cal_start = 1'b0;
    tgt_mark  = CW'($urandom_range(4095, 0));
    tgt_space = CW'($urandom_range(4095, 0));
  endtask

  task automatic wait_idle(input int limit);
    int n = 0;
    while (cal_busy && n < limit) begin
      @(negedge clk);
      n++;
    end
    if (cal_busy) check("busy_wait_expired", {31'd0, cal_busy}, 32'd0);
    @(negedge clk);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_coarse"}, {25'd0, coarse}, 32'd64);
    check({tag, "_mark"}, {25'd0, mark_code}, 32'd0);
    check({tag, "_space"}, {25'd0, space_code}, 32'd0);
    check({tag, "_cnt_start"}, {31'd0, cnt_start}, 32'd0);
    check({tag, "_busy"}, {31'd0, cal_busy}, 32'd0);
    check({tag, "_done"}, {31'd0, cal_done}, 32'd0);
    check({tag, "_err"}, {31'd0, cal_err}, 32'd0);
  endtask

  task automatic run_cal(input int tm, input int ts, input bit poke);
    logic [CODE_W-1:0] m, s;
    int base;
    m = best_code(tm);
    s = best_code(ts);
    push_trials(tm);
    push_trials(ts);
    exp_q.push_back({1'b0, 1'b1, s, m});
    prev_mark  = m;
    prev_space = s;
    base = start_cnt;
    pulse_start(tm, ts);
    if (poke) begin
      repeat ($urandom_range(60, 10)) @(negedge clk);
      pulse_start(int'($urandom_range(4095, 0)), int'($urandom_range(4095, 0)));
    end
    wait_idle(5000);
    check("cnt_start_pulses", start_cnt - base, 32'd14);
  endtask

  initial begin
    #1_000_000;
    miscompares++;
    $display("FAIL watchdog: simulation did not complete, got timeout expected completion");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    int n;
    int base;
    rst_n = 1'b0; cal_start = 1'b0; tx_data = 1'b0;
    tgt_mark = '0; tgt_space = '0;
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    stray_done = 1'b1;
    @(negedge clk);
    stray_done = 1'b0;
    repeat (2) @(negedge clk);
    check("stray_done_coarse", {25'd0, coarse}, 32'd64);
    check("stray_done_busy", {31'd0, cal_busy}, 32'd0);
    check("stray_done_cal_done", {31'd0, cal_done}, 32'd0);

    slope = 10; offset = 100;
    run_cal(800, 500, 1'b0);
    check("spec_mark_70", {25'd0, mark_code}, 32'd70);
    check("spec_space_40", {25'd0, space_code}, 32'd40);

    @(negedge clk); tx_data = 1'b1;
    @(negedge clk); check("tx1_coarse", {25'd0, coarse}, 32'd70); tx_data = 1'b0;
    @(negedge clk); check("tx0_coarse", {25'd0, coarse}, 32'd40); tx_data = 1'b1;
    @(negedge clk); check("tx1b_coarse", {25'd0, coarse}, 32'd70);

    run_cal(50, 4095, 1'b0);
    check("bound_mark_0", {25'd0, mark_code}, 32'd0);
    check("bound_space_127", {25'd0, space_code}, 32'd127);
    run_cal(740, 500, 1'b0);
    check("equal_mark_64", {25'd0, mark_code}, 32'd64);
    run_cal(800, 500, 1'b1);

    for (int i = 0; i < 6; i++) begin
      slope  = int'($urandom_range(20, 1));
      offset = int'($urandom_range(200, 0));
      tx_data = 1'($urandom_range(1, 0));
      run_cal(int'($urandom_range(4095, 0)), int'($urandom_range(4095, 0)), 1'($urandom_range(1, 0)));
      check("rand_idle_coarse", {25'd0, coarse}, {25'd0, tx_data ? prev_mark : prev_space});
    end

    resp_en = 1'b0;
    trial_q.push_back(CODE_W'(64));
    exp_q.push_back({1'b1, 1'b0, prev_space, prev_mark});
    pulse_start(800, 500);
    n = 0;
    while (!cnt_start && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("tmo_cnt_start_seen", {31'd0, cnt_start}, 32'd1);
    n = 0;
    while (!cal_err && n < 1100) begin
      @(negedge clk);
      n++;
    end
    check("tmo_latency", n, 32'd1023);
    wait_idle(10);
    check("tmo_busy", {31'd0, cal_busy}, 32'd0);
    check("tmo_coarse", {25'd0, coarse}, 32'd64);
    tx_data = 1'b1;
    @(negedge clk); tx_data = 1'b0;
    @(negedge clk);
    check("tmo_tx_ignored", {25'd0, coarse}, 32'd64);
    resp_en = 1'b1;

    slope = 10; offset = 100;
    push_trials(800);
    push_trials(500);
    exp_q.push_back({1'b0, 1'b1, 7'd40, 7'd70});
    base = start_cnt;
    pulse_start(800, 500);
    n = 0;
    while (start_cnt < base + 9 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("space_phase_reached", {31'd0, start_cnt >= base + 9}, 32'd1);
    #2 rst_n = 1'b0;
    #1 check_reset_vals("midcal_reset");
    exp_q.delete();
    trial_q.delete();
    prev_mark = '0; prev_space = '0;
    repeat (10) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    run_cal(800, 500, 1'b0);
    check("recal_mark_70", {25'd0, mark_code}, 32'd70);
    check("recal_space_40", {25'd0, space_code}, 32'd40);

    repeat (5) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
